// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a bank of common-anode 7-segment digits: double-buffered
// display value, valid/ready load port, inter-digit blanking and leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int NUM_DIG = 4,
  parameter int DWELL   = 50000,
  parameter int BLANK   = 500
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic [4*NUM_DIG-1:0] iDATA,
  input  logic [NUM_DIG-1:0]   iDP,
  input  logic                 iLZ_EN,
  input  logic                 iVALID,
  output logic                 oREADY,
  output logic [3:0]           oDIG,
  output logic                 oBLANK,
  output logic                 oDP,
  output logic [NUM_DIG-1:0]   oCOM,
  output logic                 oFRAME
);

  localparam int MAXC  = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W = $clog2(MAXC);
  localparam int IDX_W = $clog2(NUM_DIG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIG - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] SHOW_END = CNT_W'(DWELL - 1);

  typedef enum logic {GAP = 1'b0, SHOW = 1'b1} state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cntNext;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idxNext;
  logic                 r_first;
  logic                 w_firstNext;
  logic                 w_boundary;

  logic [4*NUM_DIG-1:0] r_act;
  logic [NUM_DIG-1:0]   r_actDp;
  logic                 r_actLz;
  logic [4*NUM_DIG-1:0] r_pend;
  logic [NUM_DIG-1:0]   r_pendDp;
  logic                 r_pendLz;
  logic                 r_pendFull;

  logic                 w_capture;
  logic                 w_transfer;
  logic [4*NUM_DIG-1:0] w_actNext;
  logic [NUM_DIG-1:0]   w_actDpNext;
  logic                 w_actLzNext;
  logic                 w_pendFullNext;

  logic [NUM_DIG-1:0]   w_sup;
  logic                 w_zeroAbove;

  logic                 r_ready;
  logic [3:0]           r_dig;
  logic                 r_blank;
  logic                 r_dp;
  logic [NUM_DIG-1:0]   r_com;
  logic                 r_frame;
  logic [3:0]           w_digNext;
  logic                 w_blankNext;
  logic                 w_dpNext;
  logic [NUM_DIG-1:0]   w_comNext;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= GAP;
    else         r_state <= w_stateNext;
  end

  // idx only moves when leaving a gap, so the gap after a digit still carries
  // that digit's index; the very first gap after reset must not advance it.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt + 1'b1;
    w_idxNext   = r_idx;
    w_firstNext = r_first;
    w_boundary  = 1'b0;
    case (r_state)
      GAP: begin
        if (r_cnt == GAP_END) begin
          w_cntNext   = '0;
          w_stateNext = SHOW;
          w_firstNext = 1'b0;
          if (!r_first) begin
            w_idxNext  = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            w_boundary = (r_idx == LAST_IDX);
          end
        end
      end
      SHOW: begin
        if (r_cnt == SHOW_END) begin
          w_cntNext   = '0;
          w_stateNext = GAP;
        end
      end
      default: w_stateNext = GAP;
    endcase
  end

  always_comb begin
    w_capture      = iVALID & r_ready;
    w_transfer     = w_boundary & r_pendFull;
    w_actNext      = w_transfer ? r_pend   : r_act;
    w_actDpNext    = w_transfer ? r_pendDp : r_actDp;
    w_actLzNext    = w_transfer ? r_pendLz : r_actLz;
    w_pendFullNext = r_pendFull;
    if (w_capture)       w_pendFullNext = 1'b1;
    else if (w_transfer) w_pendFullNext = 1'b0;
  end

  // Walk down from the top digit; a digit is blankable while everything at or above it is zero.
  always_comb begin
    w_zeroAbove = 1'b1;
    w_sup       = '0;
    for (int n = NUM_DIG - 1; n >= 0; n--) begin
      w_zeroAbove = w_zeroAbove & (w_actNext[4*n +: 4] == 4'h0);
      w_sup[n]    = w_actLzNext & w_zeroAbove & (n != 0);
    end
  end

  always_comb begin
    w_comNext   = '1;
    w_digNext   = 4'h0;
    w_blankNext = 1'b1;
    w_dpNext    = 1'b0;
    if (w_stateNext == SHOW) begin
      w_comNext[w_idxNext] = 1'b0;
      w_digNext            = w_actNext[{w_idxNext, 2'b00} +: 4];
      w_dpNext             = w_actDpNext[w_idxNext];
      w_blankNext          = w_sup[w_idxNext];
    end
  end

  // Outputs are registered from next-state values so they line up with the state register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_first    <= 1'b1;
      r_act      <= '0;
      r_actDp    <= '0;
      r_actLz    <= 1'b0;
      r_pend     <= '0;
      r_pendDp   <= '0;
      r_pendLz   <= 1'b0;
      r_pendFull <= 1'b0;
      r_ready    <= 1'b1;
      r_dig      <= 4'h0;
      r_blank    <= 1'b1;
      r_dp       <= 1'b0;
      r_com      <= '1;
      r_frame    <= 1'b0;
    end else begin
      r_cnt      <= w_cntNext;
      r_idx      <= w_idxNext;
      r_first    <= w_firstNext;
      r_act      <= w_actNext;
      r_actDp    <= w_actDpNext;
      r_actLz    <= w_actLzNext;
      if (w_capture) begin
        r_pend   <= iDATA;
        r_pendDp <= iDP;
        r_pendLz <= iLZ_EN;
      end
      r_pendFull <= w_pendFullNext;
      r_ready    <= ~w_pendFullNext;
      r_dig      <= w_digNext;
      r_blank    <= w_blankNext;
      r_dp       <= w_dpNext;
      r_com      <= w_comNext;
      r_frame    <= w_boundary;
    end
  end

  assign oREADY = r_ready;
  assign oDIG   = r_dig;
  assign oBLANK = r_blank;
  assign oDP    = r_dp;
  assign oCOM   = r_com;
  assign oFRAME = r_frame;

endmodule
